// File: rtl/bht_ghr_pkg.sv
// Shared types and fetch geometry for the GHR-indexed branch history table.
// The update record carries the GHR snapshot taken when the branch was predicted.
package bht_ghr_pkg;

   localparam int unsigned VLEN            = 32;
   localparam int unsigned INSTR_PER_FETCH = 2;
   localparam bit          RVC             = 1'b1;
   // Widest history any instance may use; narrower instances read the low bits.
   localparam int unsigned BHT_HIST_BITS   = 8;

   typedef enum logic [1:0] {
      BHT_BIMODAL = 2'd0,
      BHT_GSHARE  = 2'd1,
      BHT_GSELECT = 2'd2
   } bht_index_mode_e;

   typedef struct packed {
      logic                     valid;
      logic [VLEN-1:0]          pc;
      logic                     taken;
      logic                     mispredict;
      logic [BHT_HIST_BITS-1:0] ghr;
   } bht_ghr_update_t;

   typedef struct packed {
      logic valid;
      logic taken;
   } bht_prediction_t;

endpackage

// File: rtl/bht_index_hash.sv
// Combinational PC/history hash giving the table row and the slot within it.
// Used once on the fetch side and once on the commit side.
module bht_index_hash
   import bht_ghr_pkg::*;
#(
   parameter int unsigned     ROW_BITS   = 9,
   parameter int unsigned     SLOT_BITS  = 1,
   parameter int unsigned     HIST_BITS  = 8,
   parameter bht_index_mode_e INDEX_MODE = BHT_GSHARE
) (
   input  logic [VLEN-1:0]      i_pc,
   input  logic [HIST_BITS-1:0] i_ghr,
   output logic [ROW_BITS-1:0]  o_row,
   output logic [SLOT_BITS-1:0] o_slot
);

   localparam int unsigned OFFSET   = RVC ? 1 : 2;
   localparam int unsigned ROW_ADDR = $clog2(INSTR_PER_FETCH);

   logic [ROW_BITS-1:0] w_pc_row;
   logic                w_unused;

   assign w_pc_row = i_pc[ROW_BITS+ROW_ADDR+OFFSET-1 : ROW_ADDR+OFFSET];
   assign w_unused = ^{i_pc, i_ghr};

   generate
      if (RVC && ROW_ADDR > 0) begin : g_slot
         assign o_slot = SLOT_BITS'(i_pc[ROW_ADDR+OFFSET-1 : OFFSET]);
      end else begin : g_no_slot
         assign o_slot = '0;
      end

      if (INDEX_MODE == BHT_BIMODAL) begin : g_bimodal
         assign o_row = w_pc_row;
      end else if (INDEX_MODE == BHT_GSELECT) begin : g_gselect
         assign o_row = {w_pc_row[ROW_BITS-HIST_BITS-1:0], i_ghr};
      end else if (HIST_BITS >= ROW_BITS) begin : g_gshare_trunc
         assign o_row = w_pc_row ^ i_ghr[ROW_BITS-1:0];
      end else begin : g_gshare_ext
         assign o_row = w_pc_row ^ {{(ROW_BITS-HIST_BITS){1'b0}}, i_ghr};
      end
   endgenerate

endmodule

// File: rtl/bht_ghr.sv
// Branch history table of saturating counters indexed by PC hashed with a
// speculative global history register; commit updates restore exact history.
module bht_ghr
   import bht_ghr_pkg::*;
#(
   parameter int unsigned     NR_ENTRIES = 1024,
   parameter int unsigned     HIST_BITS  = 8,
   parameter int unsigned     CTR_BITS   = 2,
   parameter bht_index_mode_e INDEX_MODE = BHT_GSHARE
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    flush_i,
   input  logic                                    debug_mode_i,
   input  logic [VLEN-1:0]                         vpc_i,
   input  logic [INSTR_PER_FETCH-1:0]              spec_valid_i,
   input  logic [INSTR_PER_FETCH-1:0]              spec_taken_i,
   output logic [HIST_BITS-1:0]                    ghr_o,
   input  bht_ghr_update_t                         bht_update_i,
   output bht_prediction_t [INSTR_PER_FETCH-1:0]   bht_prediction_o
);

   localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
   localparam int unsigned SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

   typedef logic [HIST_BITS-1:0] ghr_t;
   typedef logic [CTR_BITS-1:0]  ctr_t;

   localparam ctr_t CTR_INIT = ctr_t'(1 << (CTR_BITS - 1));
   localparam ctr_t CTR_MAX  = '1;

   logic r_valid [NR_ROWS][INSTR_PER_FETCH];
   ctr_t r_ctr   [NR_ROWS][INSTR_PER_FETCH];
   ghr_t r_ghr;

   logic [ROW_BITS-1:0]  w_pred_row, w_upd_row;
   logic [SLOT_BITS-1:0] w_pred_slot, w_upd_slot;
   ghr_t                 w_upd_ghr, w_ghr_d;
   ctr_t                 w_ctr_cur, w_ctr_next;
   logic                 w_train, w_spec_any, w_spec_bit;
   logic                 w_unused;

   assign w_upd_ghr = bht_update_i.ghr[HIST_BITS-1:0];
   assign w_unused  = ^{bht_update_i, w_pred_slot};

   bht_index_hash #(
      .ROW_BITS  (ROW_BITS),
      .SLOT_BITS (SLOT_BITS),
      .HIST_BITS (HIST_BITS),
      .INDEX_MODE(INDEX_MODE)
   ) u_pred_hash (
      .i_pc  (vpc_i),
      .i_ghr (r_ghr),
      .o_row (w_pred_row),
      .o_slot(w_pred_slot)
   );

   bht_index_hash #(
      .ROW_BITS  (ROW_BITS),
      .SLOT_BITS (SLOT_BITS),
      .HIST_BITS (HIST_BITS),
      .INDEX_MODE(INDEX_MODE)
   ) u_upd_hash (
      .i_pc  (bht_update_i.pc),
      .i_ghr (w_upd_ghr),
      .o_row (w_upd_row),
      .o_slot(w_upd_slot)
   );

   always_comb begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         bht_prediction_o[i].valid = r_valid[w_pred_row][i];
         bht_prediction_o[i].taken = r_ctr[w_pred_row][i][CTR_BITS-1];
      end
   end

   assign w_train   = bht_update_i.valid && !debug_mode_i && !flush_i;
   assign w_ctr_cur = r_ctr[w_upd_row][w_upd_slot];

   always_comb begin
      if (bht_update_i.taken) begin
         w_ctr_next = (w_ctr_cur == CTR_MAX) ? w_ctr_cur : w_ctr_cur + ctr_t'(1);
      end else begin
         w_ctr_next = (w_ctr_cur == '0) ? w_ctr_cur : w_ctr_cur - ctr_t'(1);
      end
   end

   // NOTE: the table is reset because its cleared state is visible on the
   // prediction outputs right after reset; it cannot be left uninitialised.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NR_ROWS; r++) begin
            for (int s = 0; s < INSTR_PER_FETCH; s++) begin
               r_valid[r][s] <= 1'b0;
               r_ctr[r][s]   <= CTR_INIT;
            end
         end
      end else if (flush_i) begin
         for (int r = 0; r < NR_ROWS; r++) begin
            for (int s = 0; s < INSTR_PER_FETCH; s++) begin
               r_valid[r][s] <= 1'b0;
               r_ctr[r][s]   <= CTR_INIT;
            end
         end
      end else if (w_train) begin
         r_valid[w_upd_row][w_upd_slot] <= 1'b1;
         r_ctr[w_upd_row][w_upd_slot]   <= w_ctr_next;
      end
   end

   // Lowest-index valid slot wins: it is the oldest branch in the fetch group.
   always_comb begin
      w_spec_any = |spec_valid_i;
      w_spec_bit = 1'b0;
      for (int i = INSTR_PER_FETCH - 1; i >= 0; i--) begin
         if (spec_valid_i[i]) w_spec_bit = spec_taken_i[i];
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_ghr_d = r_ghr;
      if (flush_i) begin
         w_ghr_d = '0;
      end else if (debug_mode_i) begin
         w_ghr_d = r_ghr;
      end else if (bht_update_i.valid && bht_update_i.mispredict) begin
         w_ghr_d = ghr_t'({w_upd_ghr, bht_update_i.taken});
      end else if (w_spec_any) begin
         w_ghr_d = ghr_t'({r_ghr, w_spec_bit});
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_ghr <= '0;
      else         r_ghr <= w_ghr_d;
   end

   assign ghr_o = r_ghr;

endmodule

// File: tb/tb_bht_ghr.sv
// Randomised scoreboard bench for bht_ghr (16 entries, 2 slots, gshare, 2-bit history).
// The model keeps plain integer counters and history computed from the indexing rules.
module tb_bht_ghr;
   import bht_ghr_pkg::*;

   localparam int unsigned NR_ENTRIES = 16;
   localparam int unsigned HIST_BITS  = 2;
   localparam int unsigned CTR_BITS   = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_ni = 1'b0;
   logic                  flush_i = 1'b0;
   logic                  debug_mode_i = 1'b0;
   logic [VLEN-1:0]       vpc_i = '0;
   logic [1:0]            spec_valid_i = '0;
   logic [1:0]            spec_taken_i = '0;
   logic [HIST_BITS-1:0]  ghr_o;
   bht_ghr_update_t       bht_update_i = '0;
   bht_prediction_t [1:0] bht_prediction_o;

   bht_ghr #(
      .NR_ENTRIES(NR_ENTRIES),
      .HIST_BITS (HIST_BITS),
      .CTR_BITS  (CTR_BITS),
      .INDEX_MODE(BHT_GSHARE)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .debug_mode_i    (debug_mode_i),
      .vpc_i           (vpc_i),
      .spec_valid_i    (spec_valid_i),
      .spec_taken_i    (spec_taken_i),
      .ghr_o           (ghr_o),
      .bht_update_i    (bht_update_i),
      .bht_prediction_o(bht_prediction_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: 8 rows x 2 slots, counters 0..3, history 0..3.
   int m_ctr [16];
   bit m_val [16];
   int m_ghr;

   typedef struct {
      string      tag;
      logic [1:0] ghr;
      logic [1:0] valid;
      logic [1:0] taken;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   function automatic int row_of(input logic [31:0] pc, input int g);
      return int'((pc >> 2) & 32'd7) ^ (g & 3);
   endfunction

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc >> 1) & 32'd1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_ctr[i] = 2;
         m_val[i] = 1'b0;
      end
      m_ghr = 0;
   endtask

   task automatic push_expect(input string tag, input logic [31:0] vpc);
      exp_t e;
      int   r;
      r       = row_of(vpc, m_ghr);
      e.tag   = tag;
      e.ghr   = 2'(m_ghr);
      for (int s = 0; s < 2; s++) begin
         e.valid[s] = m_val[r*2+s];
         e.taken[s] = (m_ctr[r*2+s] >= 2);
      end
      q.push_back(e);
   endtask

   task automatic step(input string tag, input bit fl, input bit dbg, input logic [31:0] vpc,
                       input logic [1:0] sv, input logic [1:0] st,
                       input bit uv, input logic [31:0] upc, input bit ut, input bit um,
                       input logic [7:0] ug);
      int idx;
      int nxt;
      @(posedge clk_i);
      #1;
      rst_ni                  = 1'b1;
      flush_i                 = fl;
      debug_mode_i            = dbg;
      vpc_i                   = vpc;
      spec_valid_i            = sv;
      spec_taken_i            = st;
      bht_update_i.valid      = uv;
      bht_update_i.pc         = upc;
      bht_update_i.taken      = ut;
      bht_update_i.mispredict = um;
      bht_update_i.ghr        = ug;
      push_expect(tag, vpc);
      nxt = m_ghr;
      if (fl) begin
         model_reset();
         nxt = 0;
      end else if (!dbg) begin
         if (uv) begin
            idx        = row_of(upc, int'(ug) & 3) * 2 + slot_of(upc);
            m_val[idx] = 1'b1;
            m_ctr[idx] = ut ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                            : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
         end
         if (uv && um)        nxt = ((int'(ug) << 1) | int'(ut)) & 3;
         else if (sv != 2'b00) nxt = ((m_ghr << 1) | int'(sv[0] ? st[0] : st[1])) & 3;
      end
      m_ghr = nxt;
   endtask

   task automatic idle(input string tag, input logic [31:0] vpc);
      step(tag, 0, 0, vpc, 2'b00, 2'b00, 0, 32'h0, 0, 0, 8'h0);
   endtask

   task automatic upd(input string tag, input logic [31:0] upc, input bit ut, input logic [7:0] ug);
      step(tag, 0, 0, upc, 2'b00, 2'b00, 1, upc, ut, 0, ug);
   endtask

   task automatic async_reset();
      @(posedge clk_i);
      #3;
      rst_ni       = 1'b0;
      flush_i      = 1'b0;
      debug_mode_i = 1'b0;
      spec_valid_i = '0;
      bht_update_i = '0;
      model_reset();
      push_expect("async_rst", vpc_i);
   endtask

   // Monitor: outputs are combinational and always presented; sample mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (ghr_o !== e.ghr ||
                bht_prediction_o[0].valid !== e.valid[0] || bht_prediction_o[1].valid !== e.valid[1] ||
                bht_prediction_o[0].taken !== e.taken[0] || bht_prediction_o[1].taken !== e.taken[1]) begin
               n_miss++;
               $display("FAIL %s: got ghr=%b v=%b%b t=%b%b, want ghr=%b v=%b%b t=%b%b", e.tag,
                        ghr_o, bht_prediction_o[1].valid, bht_prediction_o[0].valid,
                        bht_prediction_o[1].taken, bht_prediction_o[0].taken,
                        e.ghr, e.valid[1], e.valid[0], e.taken[1], e.taken[0]);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk_i);

      // Reset release: all rows read invalid / weakly taken.
      for (int i = 0; i < 8; i++) idle("reset", 32'(i * 4));

      // Saturation at pc=0x8 (row 2, slot 0).
      for (int i = 0; i < 3; i++) upd("sat_up", 32'h8, 1, 8'h0);
      for (int i = 0; i < 3; i++) upd("sat_down", 32'h8, 0, 8'h0);
      idle("sat_read", 32'h8);
      idle("sat_read2", 32'h8);

      // Hash: ghr=01 steers pc=0x8 into row 3.
      step("flush_pre_hash", 1, 0, 32'h8, 2'b00, 2'b00, 0, 32'h0, 0, 0, 8'h0);
      upd("hash_upd", 32'h8, 0, 8'h1);
      upd("hash_upd", 32'h8, 0, 8'h1);
      idle("hash_row3", 32'hC);
      idle("hash_row2", 32'h8);

      // Speculation then exact recovery.
      for (int i = 0; i < 3; i++) step("spec", 0, 0, 32'h0, 2'b10, 2'b10, 0, 32'h0, 0, 0, 8'h0);
      step("mispredict", 0, 0, 32'h0, 2'b01, 2'b00, 1, 32'h10, 1, 1, 8'h0);
      idle("recovered", 32'h0);

      // Flush wins over a same-cycle update.
      step("flush_upd", 1, 0, 32'h8, 2'b01, 2'b01, 1, 32'h8, 1, 0, 8'h0);
      idle("after_flush", 32'h8);

      // Debug freezes training and history; same update afterwards trains.
      step("spec_pre_dbg", 0, 0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 0, 0, 8'h0);
      step("debug", 0, 1, 32'h8, 2'b01, 2'b00, 1, 32'hA, 0, 0, 8'h1);
      idle("debug_hold", 32'hA);
      step("debug_off", 0, 0, 32'hA, 2'b00, 2'b00, 1, 32'hA, 0, 0, 8'h1);
      idle("debug_trained", 32'hA);

      // Randomised traffic with occasional flush, debug and one async reset.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) async_reset();
         step("rand", ($urandom_range(39) == 0), ($urandom_range(7) == 0), $urandom,
              2'($urandom), 2'($urandom), 1'($urandom), $urandom, 1'($urandom),
              ($urandom_range(3) == 0), 8'($urandom));
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
      @(posedge clk_i);
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
